// File: rtl/mmio_periph_responder.sv
// mmio_periph_responder
//   Memory-mapped peripheral block for the single-cycle MIPS core. Decodes
//   addr[5:2] for accesses in the 0x4000_0000 window and provides a reloading
//   interrupt timer, LED / 7-seg registers, a synchronised switch input and a
//   UART transmitter / receiver.
//
// Ports
//   clk, reset        core clock, asynchronous active-high reset
//   rd, wr            read / write strobes (already qualified by addr[30])
//   addr, wdata       byte address (only [5:2] decoded), write data
//   rdata             combinational read data, 0 when rd=0
//   led, digi         LED and 7-seg output registers
//   switch            raw asynchronous switch inputs
//   UART_RX, UART_TX  serial in (async, idles 1) / serial out
//   irqout            timer interrupt request (TCON[2])
//
// UART FSM states (shared encoding for TX and RX)
//   state | meaning
//   IDLE  | line idle; TX waits for a TXD write, RX waits for a falling edge
//   START | start bit (RX: half-bit wait then resample to reject glitches)
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (RX: sampled, byte kept only if it reads 1)

module mmio_periph_responder #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic [11:0] digi,
  input  logic [7:0]  switch,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        irqout
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [3:0] OFF_TH   = 4'd0;
  localparam logic [3:0] OFF_TL   = 4'd1;
  localparam logic [3:0] OFF_TCON = 4'd2;
  localparam logic [3:0] OFF_LED  = 4'd3;
  localparam logic [3:0] OFF_SW   = 4'd4;
  localparam logic [3:0] OFF_DIGI = 4'd5;
  localparam logic [3:0] OFF_TXD  = 4'd6;
  localparam logic [3:0] OFF_RXD  = 4'd7;
  localparam logic [3:0] OFF_UCON = 4'd8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  logic [3:0] off;
  logic       unused_addr;
  assign off         = addr[5:2];
  assign unused_addr = ^{addr[31:6], addr[1:0]};

  logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_txd, rd_rxd, rd_ucon;
  assign wr_th   = wr && (off == OFF_TH);
  assign wr_tl   = wr && (off == OFF_TL);
  assign wr_tcon = wr && (off == OFF_TCON);
  assign wr_led  = wr && (off == OFF_LED);
  assign wr_digi = wr && (off == OFF_DIGI);
  assign wr_txd  = wr && (off == OFF_TXD);
  assign rd_rxd  = rd && (off == OFF_RXD);
  assign rd_ucon = rd && (off == OFF_UCON);

  // ---------------- timer and simple registers ----------------
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q;
  logic [11:0] digi_q;
  logic        tmr_ovf, stat_set;

  always_comb begin
    tmr_ovf  = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    stat_set = tmr_ovf && tcon_q[1];

    th_d = wr_th ? wdata : th_q;

    tl_d = tl_q;
    if (wr_tl)          tl_d = wdata;
    else if (tcon_q[0]) tl_d = tmr_ovf ? th_q : tl_q + 32'd1;

    // An overflow keeps status set against a clearing write only when that
    // write leaves the timer enabled with interrupts on.
    tcon_d = tcon_q;
    if (wr_tcon)       tcon_d = {wdata[2] | (stat_set & wdata[1] & wdata[0]), wdata[1:0]};
    else if (stat_set) tcon_d[2] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      if (wr_led)  led_q  <= wdata[7:0];
      if (wr_digi) digi_q <= wdata[11:0];
    end
  end

  // ---------------- synchronisers ----------------
  logic [7:0] sw_meta_q, sw_sync_q;
  logic       rx_meta_q, rx_sync_q, rx_prev_q;

  // RX synchroniser resets to the idle level so reset release never looks
  // like a start-bit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      rx_meta_q <= UART_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------- UART transmitter ----------------
  uart_state_e   tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_shift_q;
  logic          tx_line_q, tx_done_q, tx_busy;

  assign tx_busy = (tx_state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      if (rd_ucon) tx_done_q <= 1'b0;
      case (tx_state_q)
        IDLE: begin
          if (wr_txd) begin
            tx_shift_q <= wdata[7:0];
            tx_cnt_q   <= BIT_LAST;
            tx_line_q  <= 1'b0;
            tx_state_q <= START;
          end
        end
        START: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q   <= BIT_LAST;
            tx_line_q  <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_idx_q   <= '0;
            tx_state_q <= DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end
        end
        DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= BIT_LAST;
            if (tx_idx_q == 3'd7) begin
              tx_line_q  <= 1'b1;
              tx_state_q <= STOP;
            end else begin
              tx_line_q  <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_idx_q   <= tx_idx_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end
        end
        STOP: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= IDLE;
            tx_done_q  <= 1'b1;  // overrides a same-cycle UCON read clear
          end else begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  // ---------------- UART receiver ----------------
  uart_state_e   rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q, rxd_q;
  logic          rx_valid_q, rx_fall;

  // Edge detect needs the line to have been 1, so a receiver coming out of
  // STOP on a low line waits for it to return high first.
  assign rx_fall = rx_prev_q && !rx_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rxd_q      <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (rd_rxd) rx_valid_q <= 1'b0;
      case (rx_state_q)
        IDLE: begin
          if (rx_fall) begin
            rx_cnt_q   <= HALF_LAST;
            rx_state_q <= START;
          end
        end
        START: begin
          if (rx_cnt_q == '0) begin
            if (rx_sync_q) begin
              rx_state_q <= IDLE;
            end else begin
              rx_cnt_q   <= BIT_LAST;
              rx_idx_q   <= '0;
              rx_state_q <= DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        DATA: begin
          if (rx_cnt_q == '0) begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= BIT_LAST;
            if (rx_idx_q == 3'd7) rx_state_q <= STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        STOP: begin
          if (rx_cnt_q == '0) begin
            if (rx_sync_q) begin
              rxd_q      <= rx_shift_q;
              rx_valid_q <= 1'b1;  // new byte beats a same-cycle RXD read
            end
            rx_state_q <= IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end

  // ---------------- read mux and outputs ----------------
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        OFF_TH:   rdata = th_q;
        OFF_TL:   rdata = tl_q;
        OFF_TCON: rdata = {29'b0, tcon_q};
        OFF_LED:  rdata = {24'b0, led_q};
        OFF_SW:   rdata = {24'b0, sw_sync_q};
        OFF_DIGI: rdata = {20'b0, digi_q};
        OFF_RXD:  rdata = {24'b0, rxd_q};
        OFF_UCON: rdata = {27'b0, tx_busy, rx_valid_q, tx_done_q, 2'b0};
        default:  rdata = '0;
      endcase
    end
  end

  assign led     = led_q;
  assign digi    = digi_q;
  assign UART_TX = tx_line_q;
  assign irqout  = tcon_q[2];

endmodule

// File: tb/tb_mmio_periph_responder.sv
// tb_mmio_periph_responder
//   Randomised and directed bench for mmio_periph_responder. Timer, LED, DIGI
//   and switch behaviour are predicted by a register-level model updated once
//   per clock; UART behaviour is predicted from the serial frame format.

module tb_mmio_periph_responder;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  wire  [31:0] rdata;
  wire  [7:0]  led;
  wire  [11:0] digi;
  logic [7:0]  sw;
  logic        rx_drv, loop_en;
  wire         uart_tx, uart_rx, irq;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  mmio_periph_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led(led), .digi(digi), .switch(sw),
    .UART_RX(uart_rx), .UART_TX(uart_tx), .irqout(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // register-level model
  logic [31:0] m_th, m_tl;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led, m_meta, m_sync;
  logic [11:0] m_digi;

  logic [31:0] d, r_wd;
  logic [3:0]  r_off;
  bit          r_r, r_w;
  logic [7:0]  b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0; m_digi = '0;
    m_meta = '0; m_sync = '0;
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] off);
    case (off)
      4'd0: return m_th;
      4'd1: return m_tl;
      4'd2: return {29'b0, m_tcon};
      4'd3: return {24'b0, m_led};
      4'd4: return {24'b0, m_sync};
      4'd5: return {20'b0, m_digi};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input bit w, input logic [3:0] off, input logic [31:0] wd);
    logic [32:0] inc;
    logic        ovf, set_st;
    logic [31:0] tl_n;
    logic [2:0]  tcon_n;
    inc    = {1'b0, m_tl} + 33'd1;
    ovf    = m_tcon[0] && inc[32];
    set_st = ovf && m_tcon[1];
    tl_n   = m_tl;
    if (m_tcon[0]) tl_n = inc[32] ? m_th : inc[31:0];
    if (w && off == 4'd1) tl_n = wd;
    tcon_n = m_tcon;
    if (set_st) tcon_n[2] = 1'b1;
    if (w && off == 4'd2) begin
      tcon_n = wd[2:0];
      if (set_st && wd[1:0] == 2'b11) tcon_n[2] = 1'b1;
    end
    if (w && off == 4'd0) m_th = wd;
    if (w && off == 4'd3) m_led = wd[7:0];
    if (w && off == 4'd5) m_digi = wd[11:0];
    m_tl   = tl_n;
    m_tcon = tcon_n;
    m_sync = m_meta;
    m_meta = sw;
  endtask

  // One bus cycle: drive at posedge+1, sample rdata, commit at the edge.
  task automatic bus(input bit r, input bit w, input logic [3:0] off,
                     input logic [31:0] wd, output logic [31:0] rdat);
    rd = r; wr = w; wdata = wd;
    addr = 32'h4000_0000 | {26'b0, off, 2'b00};
    #1;
    rdat = rdata;
    if (!r) chk("rdata_idle", rdat, 32'h0);
    else if (off != 4'd7 && off != 4'd8) chk($sformatf("rd_off%0d", off), rdat, model_rd(off));
    @(posedge clk);
    model_edge(w, off, wd);
    #1;
    chk("irqout", irq, {31'b0, m_tcon[2]});
    chk("led", led, {24'b0, m_led});
    chk("digi", digi, {20'b0, m_digi});
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 4'd0, 32'h0, t);
  endtask

  function automatic logic fb(input logic [7:0] v, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return v[k-1];
  endfunction

  task automatic send_byte(input logic [7:0] v, input logic stop);
    for (int k = 0; k < 10; k++) begin
      rx_drv = (k == 9) ? stop : fb(v, k);
      idle(CPB);
    end
    rx_drv = 1'b1;
    idle(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    sw = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    chk("uart_tx_reset", uart_tx, 32'h1);
    chk("irq_reset", irq, 32'h0);
    for (int i = 0; i <= 9; i++) begin
      bus(1'b1, 1'b0, 4'(i), 32'h0, d);
      if (i == 7 || i == 8) chk("uart_reg_reset", d, 32'h0);
    end

    // randomised register / timer traffic
    for (int i = 0; i < 400; i++) begin
      r_off = 4'($urandom_range(0, 15));
      r_r   = 1'($urandom_range(0, 1));
      r_w   = (r_off != 4'd6) && ($urandom_range(0, 2) == 0);
      r_wd  = $urandom;
      if (r_off == 4'd1 && $urandom_range(0, 1) == 1) r_wd = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
      bus(r_r, r_w, r_off, r_wd, d);
      if (r_r && (r_off == 4'd7 || r_off == 4'd8)) chk("uart_rd_quiet", d, 32'h0);
    end

    // timer reload and interrupt
    bus(1'b0, 1'b1, 4'd2, 32'h0, d);
    bus(1'b0, 1'b1, 4'd0, 32'hFFFF_FFF0, d);
    bus(1'b0, 1'b1, 4'd1, 32'hFFFF_FFFD, d);
    bus(1'b0, 1'b1, 4'd2, 32'h3, d);
    bus(1'b1, 1'b0, 4'd1, 32'h0, d); chk("tl_t0", d, 32'hFFFF_FFFD);
    bus(1'b1, 1'b0, 4'd1, 32'h0, d); chk("tl_t1", d, 32'hFFFF_FFFE);
    bus(1'b1, 1'b0, 4'd1, 32'h0, d); chk("tl_t2", d, 32'hFFFF_FFFF);
    chk("irq_rise", irq, 32'h1);
    bus(1'b1, 1'b0, 4'd1, 32'h0, d); chk("tl_reload", d, 32'hFFFF_FFF0);
    bus(1'b0, 1'b1, 4'd2, 32'h3, d); chk("irq_cleared", irq, 32'h0);
    idle(13); chk("irq_before_ovf", irq, 32'h0);
    idle(1);  chk("irq_reassert", irq, 32'h1);
    bus(0, 1, 4'd2, 32'h0, d);

    // LED / DIGI / switch
    bus(1'b0, 1'b1, 4'd3, 32'hA5, d);
    bus(1'b0, 1'b1, 4'd5, 32'h3F7, d);
    chk("led_a5", led, 32'hA5);
    chk("digi_3f7", digi, 32'h3F7);
    sw = 8'h00; idle(3);
    sw = 8'h5C;
    bus(1'b1, 1'b0, 4'd4, 32'h0, d);
    bus(1'b1, 1'b0, 4'd4, 32'h0, d); chk("sw_not_yet", d, 32'h0);
    bus(1'b1, 1'b0, 4'd4, 32'h0, d); chk("sw_synced", d, 32'h5C);

    // UART TX frame, dropped write while busy, tx_done handling
    bus(1'b0, 1'b1, 4'd6, 32'h96, d);
    for (int k = 0; k < 10 * CPB; k++) begin
      chk($sformatf("tx_bit%0d", k / CPB), uart_tx, {31'b0, fb(8'h96, k / CPB)});
      if (k == 5 * CPB) bus(1'b0, 1'b1, 4'd6, 32'hFF, d);
      else begin
        bus(1'b1, 1'b0, 4'd8, 32'h0, d);
        chk("ucon_busy", d, 32'h10);
      end
    end
    chk("tx_idle_line", uart_tx, 32'h1);
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("ucon_done", d, 32'h04);
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("ucon_done_clr", d, 32'h0);
    for (int k = 0; k < 20; k++) begin
      idle(1);
      chk("tx_no_second", uart_tx, 32'h1);
    end

    // UART RX: good byte, glitch, framing error, overrun
    send_byte(8'h3C, 1'b1);
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("rx_valid_set", d, 32'h08);
    bus(1'b1, 1'b0, 4'd7, 32'h0, d); chk("rxd_3c", d, 32'h3C);
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("rx_valid_clr", d, 32'h0);
    rx_drv = 1'b0; idle(4); rx_drv = 1'b1; idle(40);
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("rx_glitch", d, 32'h0);
    b = 8'($urandom);
    send_byte(b, 1'b1);
    send_byte(8'h55, 1'b0);
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("rx_frame_err_valid", d, 32'h08);
    bus(1'b1, 1'b0, 4'd7, 32'h0, d); chk("rx_frame_err_rxd", d, {24'b0, b});
    send_byte(8'hA1, 1'b1);
    b = 8'($urandom);
    send_byte(b, 1'b1);
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("rx_overrun_valid", d, 32'h08);
    bus(1'b1, 1'b0, 4'd7, 32'h0, d); chk("rx_overrun_rxd", d, {24'b0, b});

    // loopback
    loop_en = 1'b1;
    b = 8'($urandom);
    bus(1'b0, 1'b1, 4'd6, {24'b0, b}, d);
    idle(10 * CPB + 10);
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("loop_ucon", d, 32'h0C);
    bus(1'b1, 1'b0, 4'd7, 32'h0, d); chk("loop_rxd", d, {24'b0, b});
    bus(1'b1, 1'b0, 4'd8, 32'h0, d); chk("loop_ucon_clr", d, 32'h0);

    // asynchronous reset mid-frame
    bus(1'b0, 1'b1, 4'd3, 32'h5A, d);
    bus(1'b0, 1'b1, 4'd5, 32'hABC, d);
    bus(1'b0, 1'b1, 4'd0, 32'h1234_5678, d);
    bus(1'b0, 1'b1, 4'd2, 32'h3, d);
    bus(1'b0, 1'b1, 4'd6, 32'h00, d);
    idle(40);
    chk("tx_mid_frame", uart_tx, 32'h0);
    reset = 1'b1;
    #1;
    chk("tx_async_reset", uart_tx, 32'h1);
    chk("led_async_reset", led, 32'h0);
    chk("digi_async_reset", digi, 32'h0);
    chk("irq_async_reset", irq, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i <= 9; i++) begin
      bus(1'b1, 1'b0, 4'(i), 32'h0, d);
      if (i == 7 || i == 8) chk("uart_reg_after_reset", d, 32'h0);
    end
    chk("tx_after_reset", uart_tx, 32'h1);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_periph_responder.md
Name: mmio_periph_responder

Overview:
- Memory-mapped peripheral responder for the single-cycle MIPS core. It answers the core's rd/wr/addr/wdata bus for accesses with addr[30]=1.
- Contains a programmable interrupt timer, LED and 7-seg digit registers, a synchronised switch input, and a UART transmitter/receiver.
- Drives irqout into the core's Control block.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (>=4, even).

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- rd  in  1  read strobe (MemRead & addr[30]).
- wr  in  1  write strobe (MemWrite & addr[30]).
- addr  in  32  byte address; only addr[5:2] decoded.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational.
- led  out  8  LED register.
- digi  out  12  7-seg register.
- switch  in  8  raw switches (asynchronous).
- UART_RX  in  1  serial in (asynchronous, idles 1).
- UART_TX  out  1  serial out.
- irqout  out  1  timer interrupt request.

Behaviour:
Register map (offsets from 0x40000000):
- 0x00 TH (rw 32).
- 0x04 TL (rw 32).
- 0x08 TCON (rw 3): [0] enable, [1] irq_en, [2] irq_status.
- 0x0C LED (rw 8).
- 0x10 SWITCH (ro 8).
- 0x14 DIGI (rw 12).
- 0x18 TXD (wo 8; reads 0).
- 0x1C RXD (ro 8).
- 0x20 UCON (ro): [2] tx_done, [3] rx_valid, [4] tx_busy.

Bus access:
- Unmapped offsets and addr[5:2]>8 read 0; writes to them are ignored.
- rdata = 0 when rd=0.
- Reads are combinational, same cycle; read side-effects apply at the next clk edge.
- Writes take effect at the clk edge with wr=1.
- rd and wr both high: the write is performed, and rdata returns the pre-write value.

Reset values:
- All registers, led, digi and irqout = 0.
- UART_TX = 1; both UART FSMs IDLE.

Timer:
- While TCON[0]=1, TL increments every cycle.
- When TL==0xFFFFFFFF, next TL = TH (reload, not 0); if TCON[1]=1, TCON[2] is set.
- irqout = TCON[2]. It is cleared only by a CPU write of TCON with bit2=0.
- A CPU write to TL or TCON in the same cycle as a count or reload wins.
- The status set from an overflow beats a same-cycle TCON write that clears bit2 only if that write also sets bit1 and bit0; otherwise the write wins.

Switch:
- 2-flop synchroniser; SWITCH reads {24'b0, sw_sync}.

UART TX FSM (IDLE, START, DATA, STOP):
- Write to TXD while IDLE latches wdata[7:0] and enters START next cycle; tx_busy=1 from that edge.
- Each state lasts CLKS_PER_BIT cycles: start bit 0, 8 data bits LSB first, stop bit 1.
- At the end of STOP: return to IDLE, tx_busy=0, tx_done=1.
- Write to TXD while busy is ignored (byte dropped).
- tx_done is cleared at the edge following a rd of UCON. A same-cycle completion beats the clear (stays 1).

UART RX FSM (IDLE, START, DATA, STOP):
- UART_RX passes through a 2-flop synchroniser.
- IDLE: a falling edge of the synced line enters START.
- At CLKS_PER_BIT/2 the line is resampled. If it is 1 (glitch), return to IDLE.
- Data bits are sampled every CLKS_PER_BIT thereafter, LSB first.
- Stop bit sampled 1: RXD <= byte, rx_valid=1. Stop bit 0 (framing error): byte discarded, RXD/rx_valid unchanged.
- A rd of RXD clears rx_valid at the next edge. A same-cycle new byte sets it instead (set wins).
- Overrun: a new byte overwrites RXD; rx_valid stays 1.
- After STOP, return to IDLE and wait for the line to be 1 before accepting a new falling edge.

Asynchronous reset mid-frame:
- Aborts both FSMs immediately; UART_TX = 1.

Test Plan:
- Reset, then read all offsets 0x00-0x20 and 0x24 -> all 0; UART_TX=1; irqout=0.
- Write TH=0xFFFFFFF0, TL=0xFFFFFFFD, TCON=3 -> TL reaches FFFFFFFF 2 cycles later, reloads to FFFFFFF0 on the 3rd; irqout rises the same edge. Write TCON=3 (bit2=0) -> irqout=0; the next overflow 16 cycles later re-asserts it.
- Write LED=0xA5, DIGI=0x3F7; drive switch=0x5C -> led=0xA5, digi=0x3F7; SWITCH reads 0x5C from 2 cycles after the change.
- CLKS_PER_BIT=16: write TXD=0x96 -> UART_TX shows 0,0,1,1,0,1,0,0,1,1, each bit for 16 cycles. tx_busy stays 1 throughout. A second TXD write (0xFF) mid-frame leaves no effect. After 160 cycles, UCON=0x04; the next UCON read returns 0.
- Serial 0x3C with valid stop -> UCON[3]=1, RXD=0x3C; reading RXD clears UCON[3]. A 4-cycle low glitch -> no byte. A frame 0x55 with stop=0 -> RXD stays 0x3C, rx_valid unchanged.
- Loop UART_TX to UART_RX, write TXD=0xC3 -> RXD=0xC3 with rx_valid=1. Assert reset mid-frame -> UART_TX=1 immediately, and every register is back at its reset value.
